// File: rtl/reduce_combine_table.sv
// reduce_combine_table: in-network reduction table. Contributions that share
// {contextId, tag} are folded with the flit's op until the expected number of
// children has arrived; the combined flit is then sent toward the root.
// Optional build macro REDUCE_TIMEOUT_EN adds per-entry wait counters that
// flush stale partial results with op 4'b1110.
module reduce_combine_table #(
    parameter int          FlitWidth     = 82,
    parameter int          PayloadWidth  = 32,
    parameter int          ChildrenWidth = 3,
    parameter int          TableDepth    = 8,
    parameter logic [8:0]  cur_rank      = 9'b0,
    parameter logic [2:0]  rank_x        = 3'b0,
    parameter logic [2:0]  rank_y        = 3'b0,
    parameter logic [2:0]  rank_z        = 3'b0,
    parameter logic [2:0]  root_x        = 3'b0,
    parameter logic [2:0]  root_y        = 3'b0,
    parameter logic [2:0]  root_z        = 3'b0,
    parameter int          TimeoutCycles = 255
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [FlitWidth+ChildrenWidth-1:0] in_flit,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [FlitWidth-1:0]               out_flit,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               table_full,
    output logic [$clog2(TableDepth):0]        occupancy
);

    localparam int IdxW    = $clog2(TableDepth);
    localparam int HdrW    = FlitWidth - PayloadWidth;
    localparam int OpLsb   = PayloadWidth;
    localparam int DstLsb  = FlitWidth - 10;
    localparam int SrcLsb  = FlitWidth - 19;
    localparam int RankLsb = FlitWidth - 28;
    localparam int KeyLsb  = 38;
    localparam int KeyW    = 16;

    // Reduction table storage
    logic [TableDepth-1:0]    r_valid;
    logic [HdrW-1:0]          r_hdr      [TableDepth];
    logic [PayloadWidth-1:0]  r_payload  [TableDepth];
    logic [ChildrenWidth-1:0] r_expected [TableDepth];
    logic [ChildrenWidth-1:0] r_count    [TableDepth];

    // Output register
    logic [FlitWidth-1:0] r_outFlit;
    logic                 r_outValid;

    // Decode and lookup
    logic [KeyW-1:0]          w_key;
    logic [3:0]               w_op;
    logic [ChildrenWidth-1:0] w_children;
    logic [PayloadWidth-1:0]  w_payload;
    logic                     w_flitValid;
    logic                     w_bypass;
    logic                     w_reduce;
    logic                     w_hit;
    logic [IdxW-1:0]          w_hitIdx;
    logic                     w_freeFound;
    logic [IdxW-1:0]          w_freeIdx;
    logic                     w_outFree;
    logic                     w_accept;
    logic                     w_allocate;
    logic                     w_update;
    logic                     w_complete;
    logic [PayloadWidth-1:0]  w_combined;
    logic                     w_flushGo;
    logic [IdxW-1:0]          w_flushIdx;

    function automatic logic [PayloadWidth-1:0] combine(
        input logic [3:0]              op,
        input logic [PayloadWidth-1:0] a,
        input logic [PayloadWidth-1:0] b
    );
        case (op)
            4'd0:    return a + b;
            4'd1:    return ($signed(a) > $signed(b)) ? a : b;
            4'd2:    return ($signed(a) < $signed(b)) ? a : b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            default: return a;
        endcase
    endfunction

    // Emitted flits keep the stored contextId/tag/algtype but are re-addressed to the root
    function automatic logic [FlitWidth-1:0] buildFlit(
        input logic [HdrW-1:0]         hdr,
        input logic [PayloadWidth-1:0] payload,
        input logic [3:0]              op
    );
        logic [FlitWidth-1:0] f;
        f                 = {hdr, payload};
        f[FlitWidth-1]    = 1'b1;
        f[DstLsb +: 9]    = {root_x, root_y, root_z};
        f[SrcLsb +: 9]    = {rank_x, rank_y, rank_z};
        f[RankLsb +: 9]   = cur_rank;
        f[OpLsb +: 4]     = op;
        return f;
    endfunction

    assign w_key       = in_flit[KeyLsb +: KeyW];
    assign w_op        = in_flit[OpLsb +: 4];
    assign w_children  = in_flit[FlitWidth +: ChildrenWidth];
    assign w_payload   = in_flit[PayloadWidth-1:0];
    assign w_flitValid = in_flit[FlitWidth-1];
    assign w_bypass    = w_flitValid & ((w_op > 4'd5) | (w_children <= ChildrenWidth'(1)));
    assign w_reduce    = w_flitValid & ~w_bypass;

    // Associative lookup of the incoming key and lowest-index free slot search
    always_comb begin
        w_hit       = 1'b0;
        w_hitIdx    = '0;
        w_freeFound = 1'b0;
        w_freeIdx   = '0;
        for (int i = 0; i < TableDepth; i++) begin
            if (r_valid[i] && !w_hit && (r_hdr[i][KeyLsb-PayloadWidth +: KeyW] == w_key)) begin
                w_hit    = 1'b1;
                w_hitIdx = IdxW'(i);
            end
            if (!r_valid[i] && !w_freeFound) begin
                w_freeFound = 1'b1;
                w_freeIdx   = IdxW'(i);
            end
        end
    end

    assign table_full = &r_valid;
    assign w_outFree  = ~r_outValid | out_ready;
    assign in_ready   = rst & w_outFree & (w_hit | ~table_full);
    assign w_accept   = in_valid & in_ready;
    assign w_combined = combine(r_hdr[w_hitIdx][3:0], r_payload[w_hitIdx], w_payload);
    assign w_complete = w_accept & w_reduce & w_hit &
                        ((r_count[w_hitIdx] + ChildrenWidth'(1)) == r_expected[w_hitIdx]);
    assign w_update   = w_accept & w_reduce & w_hit & ~w_complete;
    assign w_allocate = w_accept & w_reduce & ~w_hit;

`ifdef REDUCE_TIMEOUT_EN
    localparam int WaitW = $clog2(TimeoutCycles + 1);
    logic [WaitW-1:0] r_wait [TableDepth];
    logic             w_flushFound;

    // Pick the lowest expired entry; it yields to any input that loads the output
    always_comb begin
        w_flushFound = 1'b0;
        w_flushIdx   = '0;
        for (int i = 0; i < TableDepth; i++) begin
            if (r_valid[i] && !w_flushFound && (r_wait[i] == WaitW'(TimeoutCycles))) begin
                w_flushFound = 1'b1;
                w_flushIdx   = IdxW'(i);
            end
        end
        w_flushGo = w_flushFound & w_outFree & ~(w_accept & (w_bypass | w_complete)) &
                    ~(w_update & (w_hitIdx == w_flushIdx));
    end

    // Wait counters restart on allocation and on every hit, saturating at the limit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TableDepth; i++) r_wait[i] <= '0;
        end else begin
            for (int i = 0; i < TableDepth; i++) begin
                if ((w_allocate && (w_freeIdx == IdxW'(i))) || (w_update && (w_hitIdx == IdxW'(i))))
                    r_wait[i] <= '0;
                else if (r_valid[i] && (r_wait[i] != WaitW'(TimeoutCycles)))
                    r_wait[i] <= r_wait[i] + WaitW'(1);
            end
        end
    end
`else
    assign w_flushGo  = 1'b0;
    assign w_flushIdx = '0;
`endif

    // Table update: allocate on miss, fold on hit, free on completion or flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            for (int i = 0; i < TableDepth; i++) begin
                r_hdr[i]      <= '0;
                r_payload[i]  <= '0;
                r_expected[i] <= '0;
                r_count[i]    <= '0;
            end
        end else begin
            if (w_allocate) begin
                r_valid[w_freeIdx]    <= 1'b1;
                r_hdr[w_freeIdx]      <= in_flit[FlitWidth-1:PayloadWidth];
                r_payload[w_freeIdx]  <= w_payload;
                r_expected[w_freeIdx] <= w_children;
                r_count[w_freeIdx]    <= ChildrenWidth'(1);
            end
            if (w_update) begin
                r_payload[w_hitIdx] <= w_combined;
                r_count[w_hitIdx]   <= r_count[w_hitIdx] + ChildrenWidth'(1);
            end
            if (w_complete) r_valid[w_hitIdx] <= 1'b0;
            if (w_flushGo) r_valid[w_flushIdx] <= 1'b0;
        end
    end

    // One-deep output register: bypass or completion first, then a timeout flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outFlit  <= '0;
            r_outValid <= 1'b0;
        end else if (w_accept && w_bypass) begin
            r_outFlit  <= in_flit[FlitWidth-1:0];
            r_outValid <= 1'b1;
        end else if (w_complete) begin
            r_outFlit  <= buildFlit(r_hdr[w_hitIdx], w_combined, r_hdr[w_hitIdx][3:0]);
            r_outValid <= 1'b1;
        end else if (w_flushGo) begin
            r_outFlit  <= buildFlit(r_hdr[w_flushIdx], r_payload[w_flushIdx], 4'b1110);
            r_outValid <= 1'b1;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    // Occupancy is the population count of valid entries
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < TableDepth; i++)
            occupancy = occupancy + ($clog2(TableDepth)+1)'(r_valid[i]);
    end

    assign out_flit  = r_outFlit;
    assign out_valid = r_outValid;

endmodule
